// File: rtl/delay_line_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_writer_pkg
// Description : Shared word geometry, phase-slot and line encodings, and the
//               write-sequencer state type for the delay-line store.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_line_writer_pkg;

    // Word geometry: bits per stored word and width of the bit counter
    localparam int DL_WORD_W = 26;
    localparam int DL_BIT_W  = 5;

    // Phase slots within one bit time
    localparam logic [1:0] PH_W = 2'd0;
    localparam logic [1:0] PH_X = 2'd1;
    localparam logic [1:0] PH_Y = 2'd2;
    localparam logic [1:0] PH_Z = 2'd3;

    // Line select: DL44 holds PR/MD/MR/ACC, DL31 holds STP/AI/NU/PQR
    localparam logic LINE_44 = 1'b0;
    localparam logic LINE_31 = 1'b1;

    // Write sequencer: idle, shifting the word out, one-clock ack pending
    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_SHIFT = 2'd1,
        WR_DONE  = 2'd2
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/delay_line_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_writer_if
// Description : Write-request handshake between a requester and the
//               delay-line writer (level request, one-clock ack).
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_line_writer_if
    import delay_line_writer_pkg::*;
#(
    parameter int WORD_W = DL_WORD_W
);
    logic              wr_req;
    logic              wr_line;
    logic [1:0]        wr_phase;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              wr_ack;

    // Requester side
    modport master (
        output wr_req, wr_line, wr_phase, wr_data,
        input  busy, wr_ack
    );

    // Writer side
    modport slave (
        input  wr_req, wr_line, wr_phase, wr_data,
        output busy, wr_ack
    );
endinterface
`default_nettype wire

// File: rtl/dl_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : dl_bit_timer
// Description : Phase-slot and bit-number counter for the delay-line store.
//               Freezes while bit_en is low. Shared by reader and writer.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_bit_timer
    import delay_line_writer_pkg::*;
#(
    parameter int WORD_W = DL_WORD_W,
    parameter int BIT_W  = DL_BIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    output logic [1:0]       phase,
    output logic [BIT_W-1:0] bit_idx,
    output logic             word_start,
    output logic             boundary
);
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(WORD_W - 1);

    logic [1:0]       r_phase;
    logic [BIT_W-1:0] r_bit;

    // Phase advances every enabled clock; bit number advances on the Z->W wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_W;
            r_bit   <= '0;
        end else if (bit_en) begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == PH_Z) begin
                r_bit <= (r_bit == c_LAST_BIT) ? '0 : r_bit + 1'b1;
            end
        end
    end

    assign phase      = r_phase;
    assign bit_idx    = r_bit;
    assign word_start = (r_phase == PH_W) && (r_bit == '0);
    // Last slot of the word period: a write accepted here starts on W of bit 0
    assign boundary   = (r_phase == PH_Z) && (r_bit == c_LAST_BIT);

endmodule
`default_nettype wire

// File: rtl/delay_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_writer
// Description : Write side of the serial delay-line store. Recirculates the
//               sense-amp bits into DL44/DL31 and, on an accepted request,
//               substitutes one word (LSB first) into one line/phase slot.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_writer
    import delay_line_writer_pkg::*;
#(
    parameter int WORD_W = DL_WORD_W,
    parameter int BIT_W  = DL_BIT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_en,
    input  logic               dl44_sa,
    input  logic               dl31_sa,
    delay_line_writer_if.slave wr,
    output logic               dl44_gate,
    output logic               dl31_gate,
    output logic [1:0]         phase,
    output logic [BIT_W-1:0]   bit_idx,
    output logic               word_start
);
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(WORD_W - 1);

    wr_state_e         r_state;
    wr_state_e         w_state_nxt;
    logic              w_boundary;
    logic              w_accept;
    logic              w_write_slot;
    logic              r_lat_line;
    logic [1:0]        r_lat_phase;
    logic [WORD_W-1:0] r_shift;
    logic              r_ack;

    dl_bit_timer #(
        .WORD_W (WORD_W),
        .BIT_W  (BIT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .phase      (phase),
        .bit_idx    (bit_idx),
        .word_start (word_start),
        .boundary   (w_boundary)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: accept only at the word boundary; finish after the last bit's slot
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_write_slot = 1'b0;
        case (r_state)
            WR_IDLE: begin
                if (bit_en && w_boundary && wr.wr_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WR_SHIFT;
                end
            end
            WR_SHIFT: begin
                if (bit_en && (phase == r_lat_phase)) begin
                    w_write_slot = 1'b1;
                    if (bit_idx == c_LAST_BIT) begin
                        w_state_nxt = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                if (bit_en) begin
                    w_state_nxt = WR_IDLE;
                end
            end
            default: w_state_nxt = WR_IDLE;
        endcase
    end

    // Latch the request, shift the word out, drive gates and the ack pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_line  <= LINE_44;
            r_lat_phase <= PH_W;
            r_shift     <= '0;
            r_ack       <= 1'b0;
            dl44_gate   <= 1'b0;
            dl31_gate   <= 1'b0;
        end else begin
            r_ack <= (r_state == WR_DONE) && bit_en;
            if (w_accept) begin
                r_lat_line  <= wr.wr_line;
                r_lat_phase <= wr.wr_phase;
                r_shift     <= wr.wr_data;
            end else if (w_write_slot) begin
                r_shift <= {1'b0, r_shift[WORD_W-1:1]};
            end
            if (!bit_en) begin
                // Lines are not refreshed while bit timing is stopped
                dl44_gate <= 1'b0;
                dl31_gate <= 1'b0;
            end else begin
                dl44_gate <= (w_write_slot && (r_lat_line == LINE_44)) ? r_shift[0] : dl44_sa;
                dl31_gate <= (w_write_slot && (r_lat_line == LINE_31)) ? r_shift[0] : dl31_sa;
            end
        end
    end

    assign wr.busy   = (r_state == WR_SHIFT);
    assign wr.wr_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_delay_line_writer
// Description : Self-checking bench for delay_line_writer. A slot-count model
//               predicts gates, counters, busy and ack every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line_writer;
    import delay_line_writer_pkg::*;

    localparam int WORD_W    = 26;
    localparam int BIT_W     = 5;
    localparam int WORD_CLKS = 4 * WORD_W;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             bit_en  = 1'b0;
    logic             dl44_sa = 1'b0;
    logic             dl31_sa = 1'b0;
    logic             dl44_gate;
    logic             dl31_gate;
    logic [1:0]       phase;
    logic [BIT_W-1:0] bit_idx;
    logic             word_start;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: enabled-slot count since reset plus the latched write
    int                m_slots  = 0;
    bit                m_active = 1'b0;
    bit                m_pend   = 1'b0;
    logic              m_line   = 1'b0;
    int                m_lp     = 0;
    int                m_t0     = 0;
    logic [WORD_W-1:0] m_word   = '0;
    logic              exp44    = 1'b0;
    logic              exp31    = 1'b0;
    logic              exp_ack  = 1'b0;
    int                exp_ph   = 0;
    int                exp_bit  = 0;

    delay_line_writer_if #(.WORD_W(WORD_W)) wif ();

    delay_line_writer #(
        .WORD_W (WORD_W),
        .BIT_W  (BIT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .dl44_sa    (dl44_sa),
        .dl31_sa    (dl31_sa),
        .wr         (wif),
        .dl44_gate  (dl44_gate),
        .dl31_gate  (dl31_gate),
        .phase      (phase),
        .bit_idx    (bit_idx),
        .word_start (word_start)
    );

    always #5 clk = ~clk;

    // Advance one clock, update the model from the inputs seen at the edge, sample at +1
    task automatic tick();
        int  ph;
        int  bi;
        int  k;
        bit  was_active;
        bit  was_pend;
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            m_slots = 0; m_active = 1'b0; m_pend = 1'b0;
            exp44 = 1'b0; exp31 = 1'b0; exp_ack = 1'b0;
        end else begin
            exp44 = 1'b0; exp31 = 1'b0; exp_ack = 1'b0;
            if (bit_en) begin
                ph = m_slots % 4;
                bi = (m_slots / 4) % WORD_W;
                was_active = m_active;
                was_pend   = m_pend;
                exp44 = dl44_sa;
                exp31 = dl31_sa;
                if (was_pend) begin
                    exp_ack = 1'b1;
                    m_pend  = 1'b0;
                end
                if (was_active && ph == m_lp) begin
                    k = (m_slots - m_t0) / 4;
                    if (m_line) exp31 = m_word[k];
                    else        exp44 = m_word[k];
                    if (k == WORD_W - 1) begin
                        m_active = 1'b0;
                        m_pend   = 1'b1;
                    end
                end
                if (!was_active && !was_pend && wif.wr_req === 1'b1 && ph == 3 && bi == WORD_W - 1) begin
                    m_active = 1'b1;
                    m_line   = wif.wr_line;
                    m_lp     = int'(wif.wr_phase);
                    m_word   = wif.wr_data;
                    m_t0     = m_slots + 1;
                end
                m_slots = m_slots + 1;
            end
        end
        exp_ph  = m_slots % 4;
        exp_bit = (m_slots / 4) % WORD_W;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (phase !== 2'd0 || bit_idx !== '0) begin
            errors++; $display("FAIL reset_counters: got phase=%0d bit=%0d expected 0 0", phase, bit_idx);
        end
        checks++;
        if (wif.busy !== 1'b0 || wif.wr_ack !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: got busy=%b ack=%b expected 0 0", wif.busy, wif.wr_ack);
        end
        checks++;
        if (dl44_gate !== 1'b0 || dl31_gate !== 1'b0) begin
            errors++; $display("FAIL reset_gates: got %b %b expected 0 0", dl44_gate, dl31_gate);
        end
        checks++;
        if (word_start !== 1'b1) begin
            errors++; $display("FAIL reset_word_start: got %b expected 1", word_start);
        end
        rst_n  = 1'b1;
        bit_en = 1'b1;
    endtask

    task automatic test_recirc();
        int last_ws = -1;
        int ws_seen = 0;
        for (int n = 0; n < 3 * WORD_CLKS; n++) begin
            dl44_sa = 1'($urandom_range(1, 0));
            dl31_sa = 1'($urandom_range(1, 0));
            tick();
            checks++;
            if (dl44_gate !== exp44 || dl31_gate !== exp31) begin
                errors++; $display("FAIL recirc_gates cyc %0d: got %b %b expected %b %b", cyc, dl44_gate, dl31_gate, exp44, exp31);
            end
            checks++;
            if (phase !== 2'(exp_ph) || bit_idx !== BIT_W'(exp_bit)) begin
                errors++; $display("FAIL recirc_counters cyc %0d: got %0d/%0d expected %0d/%0d", cyc, phase, bit_idx, exp_ph, exp_bit);
            end
            checks++;
            if (wif.wr_ack !== 1'b0 || wif.busy !== 1'b0) begin
                errors++; $display("FAIL recirc_idle cyc %0d: got ack=%b busy=%b expected 0 0", cyc, wif.wr_ack, wif.busy);
            end
            if (word_start === 1'b1) begin
                if (last_ws >= 0) begin
                    checks++;
                    if (cyc - last_ws != WORD_CLKS) begin
                        errors++; $display("FAIL word_start_period: got %0d expected %0d", cyc - last_ws, WORD_CLKS);
                    end
                end
                last_ws = cyc;
                ws_seen++;
            end
        end
        checks++;
        if (ws_seen < 2) begin
            errors++; $display("FAIL word_start_seen: got %0d expected >=2", ws_seen);
        end
    endtask

    task automatic test_write(input string name, input logic line, input logic [1:0] lp,
                              input logic [WORD_W-1:0] data, input int req_bit, input bit clobber,
                              input int gap_bit, input int gap_len, input bit keep_req,
                              output int acc_cyc, output int ack_cyc);
        logic [WORD_W-1:0] got = '0;
        int               nbits = 0;
        int               req_cyc = cyc;
        int               gap_left = 0;
        int               want_lat;
        bit               requested = (req_bit < 0);
        bit               accepted = 1'b0;
        bit               done = 1'b0;
        bit               gap_armed = (gap_bit >= 0);
        logic             pv_busy;
        logic             pv_en;
        logic [1:0]       pv_ph;
        logic [BIT_W-1:0] pv_bit;
        acc_cyc = -1;
        ack_cyc = -1;
        for (int n = 0; n < 4 * WORD_CLKS && !done; n++) begin
            if (!requested && int'(bit_idx) == req_bit) begin
                wif.wr_req = 1'b1; wif.wr_line = line; wif.wr_phase = lp; wif.wr_data = data;
                requested = 1'b1;
                req_cyc = cyc;
            end
            if (gap_left > 0) begin
                bit_en = 1'b0;
                gap_left--;
            end else begin
                bit_en = 1'b1;
            end
            dl44_sa = 1'($urandom_range(1, 0));
            dl31_sa = 1'($urandom_range(1, 0));
            pv_busy = wif.busy; pv_en = bit_en; pv_ph = phase; pv_bit = bit_idx;
            tick();
            checks++;
            if (dl44_gate !== exp44 || dl31_gate !== exp31) begin
                errors++; $display("FAIL %s gates cyc %0d: got %b %b expected %b %b", name, cyc, dl44_gate, dl31_gate, exp44, exp31);
            end
            checks++;
            if (phase !== 2'(exp_ph) || bit_idx !== BIT_W'(exp_bit)) begin
                errors++; $display("FAIL %s counters cyc %0d: got %0d/%0d expected %0d/%0d", name, cyc, phase, bit_idx, exp_ph, exp_bit);
            end
            checks++;
            if (wif.busy !== m_active) begin
                errors++; $display("FAIL %s busy cyc %0d: got %b expected %b", name, cyc, wif.busy, m_active);
            end
            checks++;
            if (wif.wr_ack !== exp_ack) begin
                errors++; $display("FAIL %s ack cyc %0d: got %b expected %b", name, cyc, wif.wr_ack, exp_ack);
            end
            if (!pv_en) begin
                checks++;
                if (dl44_gate !== 1'b0 || dl31_gate !== 1'b0 || phase !== pv_ph || bit_idx !== pv_bit) begin
                    errors++; $display("FAIL %s gap_freeze cyc %0d: got gates %b %b ctr %0d/%0d expected 0 0 %0d/%0d",
                                       name, cyc, dl44_gate, dl31_gate, phase, bit_idx, pv_ph, pv_bit);
                end
            end
            if (pv_busy === 1'b1 && pv_en && pv_ph == lp) begin
                if (nbits < WORD_W) got[nbits] = line ? dl31_gate : dl44_gate;
                nbits++;
            end
            if (!accepted && wif.busy === 1'b1) begin
                accepted = 1'b1;
                acc_cyc = cyc;
                checks++;
                if (phase !== 2'd0 || bit_idx !== '0 || cyc - req_cyc > WORD_CLKS) begin
                    errors++; $display("FAIL %s accept_boundary: got ctr %0d/%0d wait %0d expected 0/0 wait<=%0d",
                                       name, phase, bit_idx, cyc - req_cyc, WORD_CLKS);
                end
                if (clobber) begin
                    wif.wr_data = '1; wif.wr_line = ~line; wif.wr_phase = lp + 2'd1;
                end
            end
            if (accepted && gap_armed && int'(bit_idx) == gap_bit && phase == 2'd0 && wif.busy === 1'b1) begin
                gap_armed = 1'b0;
                gap_left  = gap_len;
            end
            if (wif.wr_ack === 1'b1) begin
                done = 1'b1;
                ack_cyc = cyc;
                if (!keep_req) wif.wr_req = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout: got no ack expected ack within %0d clocks", name, 4 * WORD_CLKS);
            wif.wr_req = 1'b0;
        end else begin
            want_lat = 4 * (WORD_W - 1) + int'(lp) + 2 + ((gap_bit >= 0) ? gap_len : 0);
            checks++;
            if (ack_cyc - acc_cyc != want_lat) begin
                errors++; $display("FAIL %s latency: got %0d expected %0d", name, ack_cyc - acc_cyc, want_lat);
            end
            checks++;
            if (nbits != WORD_W) begin
                errors++; $display("FAIL %s bit_count: got %0d expected %0d", name, nbits, WORD_W);
            end
            checks++;
            if (got !== data) begin
                errors++; $display("FAIL %s stream: got %h expected %h", name, got, data);
            end
            checks++;
            if (wif.busy !== 1'b0) begin
                errors++; $display("FAIL %s busy_at_ack: got %b expected 0", name, wif.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a1, k1, a2, k2;
        test_write("b2b_first", LINE_44, PH_X, 26'h15A5A5A, 3, 1'b0, -1, 0, 1'b1, a1, k1);
        wif.wr_data = 26'h0F0F0F3; wif.wr_line = LINE_31; wif.wr_phase = PH_X;
        test_write("b2b_second", LINE_31, PH_X, 26'h0F0F0F3, -1, 1'b0, -1, 0, 1'b0, a2, k2);
        checks++;
        if (a2 != k1 + 1) begin
            errors++; $display("FAIL b2b_accept_on_ack: got accept at %0d expected %0d", a2, k1 + 1);
        end
    endtask

    task automatic test_reset_mid_write();
        int  rel_cyc;
        int  acc_cyc = -1;
        bit  reached = 1'b0;
        bit  done = 1'b0;
        wif.wr_req = 1'b1; wif.wr_line = LINE_31; wif.wr_phase = PH_Z;
        wif.wr_data = WORD_W'($urandom);
        bit_en = 1'b1;
        for (int n = 0; n < 3 * WORD_CLKS && !reached; n++) begin
            dl44_sa = 1'($urandom_range(1, 0));
            dl31_sa = 1'($urandom_range(1, 0));
            tick();
            checks++;
            if (dl44_gate !== exp44 || dl31_gate !== exp31 || wif.busy !== m_active || wif.wr_ack !== exp_ack) begin
                errors++; $display("FAIL rst_pre cyc %0d: got %b%b busy=%b ack=%b expected %b%b busy=%b ack=%b",
                                   cyc, dl44_gate, dl31_gate, wif.busy, wif.wr_ack, exp44, exp31, m_active, exp_ack);
            end
            if (wif.busy === 1'b1 && bit_idx == BIT_W'(8)) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL rst_reach_bit8: got not reached expected busy at bit 8");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dl44_gate !== 1'b0 || dl31_gate !== 1'b0 || wif.busy !== 1'b0 || wif.wr_ack !== 1'b0 ||
            phase !== 2'd0 || bit_idx !== '0) begin
            errors++; $display("FAIL rst_abort: got gates %b%b busy=%b ack=%b ctr %0d/%0d expected all 0",
                               dl44_gate, dl31_gate, wif.busy, wif.wr_ack, phase, bit_idx);
        end
        repeat (3) begin
            tick();
            checks++;
            if (wif.wr_ack !== 1'b0 || wif.busy !== 1'b0) begin
                errors++; $display("FAIL rst_hold: got ack=%b busy=%b expected 0 0", wif.wr_ack, wif.busy);
            end
        end
        rst_n = 1'b1;
        rel_cyc = cyc;
        for (int n = 0; n < 3 * WORD_CLKS && !done; n++) begin
            dl44_sa = 1'($urandom_range(1, 0));
            dl31_sa = 1'($urandom_range(1, 0));
            tick();
            checks++;
            if (dl44_gate !== exp44 || dl31_gate !== exp31 || wif.busy !== m_active || wif.wr_ack !== exp_ack) begin
                errors++; $display("FAIL rst_post cyc %0d: got %b%b busy=%b ack=%b expected %b%b busy=%b ack=%b",
                                   cyc, dl44_gate, dl31_gate, wif.busy, wif.wr_ack, exp44, exp31, m_active, exp_ack);
            end
            if (acc_cyc < 0 && wif.busy === 1'b1) acc_cyc = cyc;
            if (wif.wr_ack === 1'b1) begin
                done = 1'b1;
                wif.wr_req = 1'b0;
                checks++;
                if (cyc - acc_cyc != 4 * (WORD_W - 1) + 3 + 2) begin
                    errors++; $display("FAIL rst_rewrite_latency: got %0d expected %0d", cyc - acc_cyc, 4 * (WORD_W - 1) + 5);
                end
            end
        end
        checks++;
        if (acc_cyc - rel_cyc != WORD_CLKS) begin
            errors++; $display("FAIL rst_reaccept: got %0d clocks after release expected %0d", acc_cyc - rel_cyc, WORD_CLKS);
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL rst_rewrite_ack: got no ack expected ack");
            wif.wr_req = 1'b0;
        end
    endtask

    task automatic test_random();
        int a, k;
        for (int i = 0; i < 4; i++) begin
            test_write("random", 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), WORD_W'($urandom),
                       int'($urandom_range(WORD_W - 1, 0)), 1'b0, -1, 0, 1'b0, a, k);
        end
    endtask

    initial begin
        int a, k;
        wif.wr_req = 1'b0; wif.wr_line = 1'b0; wif.wr_phase = 2'd0; wif.wr_data = '0;
        test_reset();
        test_recirc();
        test_write("dl44_mr", LINE_44, PH_Y, 26'h2AAAAAA, 5, 1'b0, -1, 0, 1'b0, a, k);
        test_write("dl31_stp", LINE_31, PH_W, 26'h0000001, 0, 1'b0, -1, 0, 1'b0, a, k);
        test_write("clobber", LINE_44, PH_X, 26'h1234567, 20, 1'b1, -1, 0, 1'b0, a, k);
        test_write("gap", LINE_31, PH_Z, 26'h2C3A5F1, 10, 1'b0, 12, 10, 1'b0, a, k);
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
